smart_systolic_operand_feeder: RTL and testbench

//  Transmit side of the systolic array's left/top operand interface. Accepts one

---
 rtl/smart_systolic_operand_feeder_if.sv | 28 ++
 rtl/smart_systolic_operand_feeder.sv | 114 +++++++++++
 tb/tb_smart_systolic_operand_feeder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/smart_systolic_operand_feeder_if.sv
// Operand beat stream into the feeder and the skewed buses and status it drives
// toward the systolic array.
interface smart_systolic_operand_feeder_if #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int WORD_SIZE = 16
);
  logic                      s_valid;
  logic                      s_ready;
  logic                      s_last;
  logic [ROWS*WORD_SIZE-1:0] s_left_vec;
  logic [COLS*WORD_SIZE-1:0] s_top_vec;
  logic [ROWS*WORD_SIZE-1:0] left_in_bus;
  logic [COLS*WORD_SIZE-1:0] top_in_bus;
  logic                      ctl_stat_bit_out;
  logic                      busy;
  logic                      done;

  modport master (
    output s_valid, s_last, s_left_vec, s_top_vec,
    input  s_ready, left_in_bus, top_in_bus, ctl_stat_bit_out, busy, done
  );

  modport slave (
    input  s_valid, s_last, s_left_vec, s_top_vec,
    output s_ready, left_in_bus, top_in_bus, ctl_stat_bit_out, busy, done
  );
endinterface

// File: rtl/smart_systolic_operand_feeder.sv
// Skews one left/top operand wavefront per beat into the systolic array edges and
// flushes the skew chains with zeros after the last beat of a tile.
//
// state | meaning
// IDLE  | waiting for the first beat of a tile
// RUN   | accepting beats; idle cycles inject zero bubbles
// DRAIN | last beat taken, zeros flush the deepest lane for D cycles
// DONE  | last word on deepest lane, one-cycle done pulse
module smart_systolic_operand_feeder #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int WORD_SIZE = 16
) (
  input logic                          clk,
  input logic                          rst,
  smart_systolic_operand_feeder_if.slave bus
);
  localparam int MAXRC = (ROWS > COLS) ? ROWS : COLS;
  localparam int D     = MAXRC - 1;
  localparam int CW    = (MAXRC > 1) ? $clog2(MAXRC) : 1;
  localparam logic [CW-1:0] DRAIN_LOAD = (D == 0) ? '0 : CW'(D - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            stat_q, busy_q, done_q;
  logic            ready;
  logic            accept;

  assign ready                = (state_q == IDLE) || (state_q == RUN);
  assign accept               = bus.s_valid && ready;
  assign bus.s_ready          = ready;
  assign bus.ctl_stat_bit_out = stat_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          if (bus.s_last) begin
            state_d = DRAIN;
            cnt_d   = DRAIN_LOAD;
          end else begin
            state_d = RUN;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stat_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stat_q  <= (state_d == RUN) || (state_d == DRAIN);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  // Lane k is a (k+1)-word shift register; its oldest word drives the bus.
  for (genvar r = 0; r < ROWS; r++) begin : g_left
    logic [(r+1)*WORD_SIZE-1:0] sr_q;
    logic [WORD_SIZE-1:0]       in_w;
    assign in_w = accept ? bus.s_left_vec[r*WORD_SIZE +: WORD_SIZE] : '0;
    if (r == 0) begin : g_stage
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr_q <= '0;
        else      sr_q <= in_w;
      end
    end else begin : g_stage
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr_q <= '0;
        else      sr_q <= {sr_q[r*WORD_SIZE-1:0], in_w};
      end
    end
    assign bus.left_in_bus[r*WORD_SIZE +: WORD_SIZE] = sr_q[(r+1)*WORD_SIZE-1 -: WORD_SIZE];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_top
    logic [(c+1)*WORD_SIZE-1:0] sr_q;
    logic [WORD_SIZE-1:0]       in_w;
    assign in_w = accept ? bus.s_top_vec[c*WORD_SIZE +: WORD_SIZE] : '0;
    if (c == 0) begin : g_stage
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr_q <= '0;
        else      sr_q <= in_w;
      end
    end else begin : g_stage
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr_q <= '0;
        else      sr_q <= {sr_q[c*WORD_SIZE-1:0], in_w};
      end
    end
    assign bus.top_in_bus[c*WORD_SIZE +: WORD_SIZE] = sr_q[(c+1)*WORD_SIZE-1 -: WORD_SIZE];
  end
endmodule

// File: tb/tb_smart_systolic_operand_feeder.sv
// Directed bench for the operand feeder with ROWS=COLS=4, WORD_SIZE=16 (D=3).
module tb_smart_systolic_operand_feeder;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int W    = 16;
  localparam int LW   = ROWS * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  smart_systolic_operand_feeder_if #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W)) bus ();

  smart_systolic_operand_feeder #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int k      = 0;
  logic [LW-1:0] hl [0:31];
  logic [LW-1:0] ht [0:31];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 32; i++) begin
      hl[i] = '0;
      ht[i] = '0;
    end
    k = 0;
  endtask

  task automatic drive(input bit v, input bit l, input logic [LW-1:0] lv, input logic [LW-1:0] tv);
    bus.s_valid    = v;
    bus.s_last     = l;
    bus.s_left_vec = lv;
    bus.s_top_vec  = tv;
  endtask

  // Drives a beat the bench expects to be accepted in cycle k.
  task automatic beat(input bit l, input logic [LW-1:0] lv, input logic [LW-1:0] tv);
    drive(1'b1, l, lv, tv);
    hl[k] = lv;
    ht[k] = tv;
  endtask

  function automatic logic [LW-1:0] vec(input logic [15:0] base);
    return {base + 16'd3, base + 16'd2, base + 16'd1, base};
  endfunction

  // Lane r in cycle n carries lane r of the beat accepted in cycle n-1-r.
  function automatic logic [LW-1:0] exp_lanes(input bit top, input int n);
    logic [LW-1:0] res;
    logic [LW-1:0] w;
    int idx;
    res = '0;
    for (int r = 0; r < ROWS; r++) begin
      idx = n - 1 - r;
      if (idx >= 0 && idx < 32) begin
        w = top ? ht[idx] : hl[idx];
        res[r*W +: W] = w[r*W +: W];
      end
    end
    return res;
  endfunction

  task automatic chk_out(input string tag, input bit rdy, input bit bsy, input bit stat, input bit dn);
    chk($sformatf("%s k%0d left", tag, k), bus.left_in_bus, exp_lanes(1'b0, k));
    chk($sformatf("%s k%0d top", tag, k), bus.top_in_bus, exp_lanes(1'b1, k));
    chk($sformatf("%s k%0d s_ready", tag, k), bus.s_ready, rdy);
    chk($sformatf("%s k%0d busy", tag, k), bus.busy, bsy);
    chk($sformatf("%s k%0d stat", tag, k), bus.ctl_stat_bit_out, stat);
    chk($sformatf("%s k%0d done", tag, k), bus.done, dn);
  endtask

  task automatic single_tile(input string tag);
    clear_hist();
    beat(1'b1, vec(16'd1), vec(16'd5));
    chk_out(tag, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    for (int c = 1; c <= 5; c++) begin
      chk_out(tag, c == 5, c <= 4, c <= 3, c == 4);
      if (c < 5) tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 1'b0, '0, '0);
    clear_hist();

    // 1: asynchronous reset before any clock edge
    #2 rst = 1'b0;
    #1;
    chk("rst left", bus.left_in_bus, '0);
    chk("rst top", bus.top_in_bus, '0);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst done", bus.done, 1'b0);
    chk("rst stat", bus.ctl_stat_bit_out, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel s_ready", bus.s_ready, 1'b1);
    chk("rel busy", bus.busy, 1'b0);

    // 2: single last beat
    single_tile("t2");

    // 3+4: A, B, gap, C(last), then new data held during DRAIN/DONE
    clear_hist();
    beat(1'b0, vec(16'hA000), vec(16'h1A00));
    chk_out("t3", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    beat(1'b0, vec(16'hB000), vec(16'h1B00));
    chk_out("t3", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    chk_out("t3", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    beat(1'b1, vec(16'hC000), vec(16'h1C00));
    chk_out("t3", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3 lane2 A", bus.left_in_bus[47:32], 16'hA002);
    tick();
    drive(1'b1, 1'b0, vec(16'hD000), vec(16'h1D00));
    chk("t3 lane2 B", bus.left_in_bus[47:32], 16'hB002);
    for (int c = 4; c <= 7; c++) begin
      if (c == 5) chk("t3 lane2 gap", bus.left_in_bus[47:32], 16'h0000);
      if (c == 6) chk("t3 lane2 C", bus.left_in_bus[47:32], 16'hC002);
      chk_out("t4", 1'b0, 1'b1, c <= 6, c == 7);
      tick();
    end
    chk_out("t4", 1'b1, 1'b0, 1'b0, 1'b0);
    beat(1'b0, vec(16'hD000), vec(16'h1D00));
    tick();
    chk_out("t4", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t4 lane0 D", bus.left_in_bus[15:0], 16'hD000);
    beat(1'b1, vec(16'hE000), vec(16'h1E00));
    tick();
    drive(1'b0, 1'b0, '0, '0);
    for (int c = 10; c <= 14; c++) begin
      chk_out("t4 end", c == 14, c <= 13, c <= 12, c == 13);
      if (c < 14) tick();
    end

    // 5: reset in second DRAIN cycle
    clear_hist();
    beat(1'b1, vec(16'd1), vec(16'd5));
    tick();
    drive(1'b0, 1'b0, '0, '0);
    chk_out("t5 pre", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    #1 rst = 1'b0;
    #1;
    chk("t5 rst left", bus.left_in_bus, '0);
    chk("t5 rst top", bus.top_in_bus, '0);
    chk("t5 rst busy", bus.busy, 1'b0);
    chk("t5 rst stat", bus.ctl_stat_bit_out, 1'b0);
    chk("t5 rst done", bus.done, 1'b0);
    #3 rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("t5 post%0d done", c), bus.done, 1'b0);
      chk($sformatf("t5 post%0d left", c), bus.left_in_bus, '0);
      chk($sformatf("t5 post%0d busy", c), bus.busy, 1'b0);
    end
    single_tile("t5 tile");

    // 6: six consecutive beats
    clear_hist();
    for (int i = 0; i < 6; i++) begin
      chk_out("t6", 1'b1, i > 0, i > 0, 1'b0);
      beat(i == 5, vec(16'(256 * (i + 1))), vec(16'(16'h8000 + 256 * (i + 1))));
      tick();
    end
    drive(1'b0, 1'b0, '0, '0);
    for (int c = 6; c <= 10; c++) begin
      chk_out("t6", c == 10, c <= 9, c <= 8, c == 9);
      if (c < 10) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
